// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control/data bundle for jk_reg_bank.
//   master drives : en, mode, j, k, load, d, ser_in
//   slave drives  : q, qb, ser_out, tc, wrap
interface jk_reg_bank_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             ser_out;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, load, d, ser_in,
        input  q, qb, ser_out, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, load, d, ser_in,
        output q, qb, ser_out, tc, wrap
    );
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit register with per-bit JK, up/down count and
// shift-left modes, plus parallel load. Per-edge priority: rst, load, en.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, loads RST_VAL
//   bus  : jk_reg_bank_if.slave
//          inputs  en, mode[1:0], j, k, load, d, ser_in
//          outputs q (registered), qb = ~q, ser_out = q[MSB],
//                  tc (terminal count, combinational), wrap (registered pulse)
module jk_reg_bank #(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    jk_reg_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_UP  = 2'b01,
        MODE_DN  = 2'b10,
        MODE_SHL = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             w_all_ones;
    logic             w_all_zeros;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    assign w_mode      = mode_t'(bus.mode);
    assign w_all_ones  = &r_q;
    assign w_all_zeros = ~|r_q;

    // Next value for an enabled edge. Wrap is only flagged for counting
    // modes; JK toggles and shifts that pass through 0/all-ones do not count.
    always_comb begin
        w_next      = r_q;
        w_wrap_next = 1'b0;
        case (w_mode)
            MODE_JK: begin
                // JK per bit: 00 hold, 01 clear, 10 set, 11 toggle
                w_next = (bus.j & ~r_q) | (~bus.k & r_q);
            end
            MODE_UP: begin
                w_next      = r_q + ONE;
                w_wrap_next = w_all_ones;
            end
            MODE_DN: begin
                w_next      = r_q - ONE;
                w_wrap_next = w_all_zeros;
            end
            MODE_SHL: begin
                w_next = {r_q[WIDTH-2:0], bus.ser_in};
            end
            default: begin
                w_next      = r_q;
                w_wrap_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RST_VAL;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_q    <= bus.d;
            r_wrap <= 1'b0;
        end else if (bus.en) begin
            r_q    <= w_next;
            r_wrap <= w_wrap_next;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.q       = r_q;
    assign bus.qb      = ~r_q;
    assign bus.ser_out = r_q[WIDTH-1];
    assign bus.tc      = ((w_mode == MODE_UP) && w_all_ones) ||
                         ((w_mode == MODE_DN) && w_all_zeros);
    assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jk_reg_bank_if #(.WIDTH(4)) bus0 ();
    jk_reg_bank_if #(.WIDTH(4)) bus1 ();

    // Second instance (RST_VAL = 4'hA) sees the same stimulus.
    assign bus1.en     = bus0.en;
    assign bus1.mode   = bus0.mode;
    assign bus1.j      = bus0.j;
    assign bus1.k      = bus0.k;
    assign bus1.load   = bus0.load;
    assign bus1.d      = bus0.d;
    assign bus1.ser_in = bus0.ser_in;

    jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    jk_reg_bank #(.WIDTH(4), .RST_VAL(4'hA)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer arithmetic on the register value.
    int m_q[2];
    bit m_wrap[2];
    bit m_valid = 0;
    int m_rv[2] = '{0, 10};

    function automatic int mnext(int q, int m, logic [3:0] jj, logic [3:0] kk, logic s);
        int r;
        r = q;
        case (m)
            0: begin
                r = 0;
                for (int b = 0; b < 4; b++) begin
                    int bit_q;
                    bit_q = (q >> b) & 1;
                    if (jj[b] && kk[b])      bit_q = 1 - bit_q;
                    else if (jj[b])          bit_q = 1;
                    else if (kk[b])          bit_q = 0;
                    r = r + (bit_q << b);
                end
            end
            1: r = (q + 1) % 16;
            2: r = (q + 15) % 16;
            default: r = (q * 2 + (s ? 1 : 0)) % 16;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_q[i] = m_rv[i];
                m_wrap[i] = 0;
            end else if (m_valid) begin
                if (bus0.load) begin
                    m_q[i] = int'(bus0.d);
                    m_wrap[i] = 0;
                end else if (bus0.en) begin
                    int nq;
                    nq = mnext(m_q[i], int'(bus0.mode), bus0.j, bus0.k, bus0.ser_in);
                    m_wrap[i] = (bus0.mode == 2'd1 && m_q[i] == 15 && nq == 0) ||
                                (bus0.mode == 2'd2 && m_q[i] == 0 && nq == 15);
                    m_q[i] = nq;
                end else begin
                    m_wrap[i] = 0;
                end
            end
        end
        if (rst) m_valid = 1;
    end

    function automatic logic m_tc(int q);
        return (bus0.mode == 2'd1 && q == 15) || (bus0.mode == 2'd2 && q == 0);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("d0.q",       32'(bus0.q),       32'(m_q[0]));
            chk("d0.qb",      32'(bus0.qb),      32'(15 - m_q[0]));
            chk("d0.ser_out", 32'(bus0.ser_out), 32'((m_q[0] >> 3) & 1));
            chk("d0.tc",      32'(bus0.tc),      32'(m_tc(m_q[0])));
            chk("d0.wrap",    32'(bus0.wrap),    32'(m_wrap[0]));
            chk("d1.q",       32'(bus1.q),       32'(m_q[1]));
            chk("d1.qb",      32'(bus1.qb),      32'(15 - m_q[1]));
            chk("d1.ser_out", 32'(bus1.ser_out), 32'((m_q[1] >> 3) & 1));
            chk("d1.tc",      32'(bus1.tc),      32'(m_tc(m_q[1])));
            chk("d1.wrap",    32'(bus1.wrap),    32'(m_wrap[1]));
        end
    end

    // Apply one vector, let one rising edge consume it, return 1 time unit later.
    task automatic step(input logic r, input logic l, input logic e, input logic [1:0] m,
                        input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                        input logic s);
        rst         = r;
        bus0.load   = l;
        bus0.en     = e;
        bus0.mode   = m;
        bus0.j      = jj;
        bus0.k      = kk;
        bus0.d      = dd;
        bus0.ser_in = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.load = 0; bus0.en = 0; bus0.mode = 0; bus0.j = 0; bus0.k = 0;
        bus0.d = 0; bus0.ser_in = 0;

        // Reset values for both RST_VAL settings
        step(1, 1, 1, 2'd1, 4'hF, 4'hF, 4'h5, 1);
        chk("rst.q0", 32'(bus0.q), 32'h0);
        chk("rst.qb0", 32'(bus0.qb), 32'hF);
        chk("rst.wrap0", 32'(bus0.wrap), 32'h0);
        chk("rst.q1", 32'(bus1.q), 32'hA);
        chk("rst.qb1", 32'(bus1.qb), 32'h5);

        // Per-bit JK
        step(0, 0, 1, 2'd0, 4'hC, 4'hA, 4'h0, 0);
        chk("jk1.q0", 32'(bus0.q), 32'hC);
        chk("jk1.q1", 32'(bus1.q), 32'h4);
        step(0, 0, 1, 2'd0, 4'hC, 4'hA, 4'h0, 0);
        chk("jk2.q0", 32'(bus0.q), 32'h4);
        chk("jk2.q1", 32'(bus1.q), 32'hC);

        // Count up through wrap
        step(0, 1, 1, 2'd1, 4'h0, 4'h0, 4'hE, 0);
        chk("up.load", 32'(bus0.q), 32'hE);
        step(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("up.F", 32'(bus0.q), 32'hF);
        chk("up.tc", 32'(bus0.tc), 32'h1);
        step(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("up.0", 32'(bus0.q), 32'h0);
        chk("up.wrap", 32'(bus0.wrap), 32'h1);
        step(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("up.1", 32'(bus0.q), 32'h1);
        chk("up.nowrap", 32'(bus0.wrap), 32'h0);

        // Count down through wrap, then hold
        step(0, 1, 0, 2'd2, 4'h0, 4'h0, 4'h1, 0);
        step(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0);
        chk("dn.0", 32'(bus0.q), 32'h0);
        chk("dn.tc", 32'(bus0.tc), 32'h1);
        step(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0);
        chk("dn.F", 32'(bus0.q), 32'hF);
        chk("dn.wrap", 32'(bus0.wrap), 32'h1);
        step(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0, 0);
        chk("dn.hold", 32'(bus0.q), 32'hF);
        chk("dn.hwrap", 32'(bus0.wrap), 32'h0);

        // Shift left, then load with en=0
        step(0, 1, 0, 2'd3, 4'h0, 4'h0, 4'h0, 0);
        step(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1);
        step(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 0);
        step(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1);
        step(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1);
        chk("shl.q", 32'(bus0.q), 32'hB);
        chk("shl.ser", 32'(bus0.ser_out), 32'h1);
        chk("shl.tc", 32'(bus0.tc), 32'h0);
        step(0, 1, 0, 2'd3, 4'h0, 4'h0, 4'h6, 0);
        chk("shl.load", 32'(bus0.q), 32'h6);

        // rst beats load; load beats en
        step(0, 1, 0, 2'd1, 4'h0, 4'h0, 4'h7, 0);
        step(1, 1, 1, 2'd1, 4'h0, 4'h0, 4'h9, 0);
        chk("pri.rst", 32'(bus0.q), 32'h0);
        chk("pri.rwrap", 32'(bus0.wrap), 32'h0);
        step(0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h9, 0);
        chk("pri.load", 32'(bus0.q), 32'h9);

        // Reset on the edge that would wrap, and right after a wrap
        step(0, 1, 0, 2'd1, 4'h0, 4'h0, 4'hF, 0);
        step(1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("rstwrap.w", 32'(bus0.wrap), 32'h0);
        step(0, 1, 0, 2'd1, 4'h0, 4'h0, 4'hF, 0);
        step(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        step(1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("rstafter.w", 32'(bus0.wrap), 32'h0);
        chk("rstafter.q1", 32'(bus1.q), 32'hA);

        // JK toggle and shift through 0 do not flag wrap; load of 0 neither
        step(0, 1, 0, 2'd0, 4'h0, 4'h0, 4'hF, 0);
        step(0, 0, 1, 2'd0, 4'hF, 4'hF, 4'h0, 0);
        chk("jkwrap.q", 32'(bus0.q), 32'h0);
        chk("jkwrap.w", 32'(bus0.wrap), 32'h0);

        // Mode change takes effect on the same edge
        step(0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h5, 0);
        step(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0);
        chk("modechg", 32'(bus0.q), 32'h4);

        // Pulse on rst between edges has no effect
        bus0.en = 0; bus0.load = 0;
        #1 rst = 1;
        #1 rst = 0;
        step(0, 0, 0, 2'd1, 4'h0, 4'h0, 4'h0, 0);
        chk("glitch.q0", 32'(bus0.q), 32'h4);

        // Mixed vectors, model-checked each cycle
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        step(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q by reset.
REQ-003 clk  input  1  clock; all state changes on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  operation enable for the JK, count and shift modes.
REQ-006 mode  input  2  00 per-bit JK, 01 count up, 10 count down, 11 shift left.
REQ-007 j  input  WIDTH  per-bit J inputs, used in mode 00 only.
REQ-008 k  input  WIDTH  per-bit K inputs, used in mode 00 only.
REQ-009 load  input  1  parallel load strobe.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 ser_in  input  1  serial input, shifted into bit 0 in mode 11.
REQ-012 q  output  WIDTH  register state, registered.
REQ-013 qb  output  WIDTH  bitwise complement of q at all times.
REQ-014 ser_out  output  1  equal to q[WIDTH-1], combinational.
REQ-015 tc  output  1  terminal count, combinational: q all-ones in mode 01, q all-zeros in mode 10, 0 in modes 00 and 11.
REQ-016 wrap  output  1  registered one-cycle pulse flagging a count wrap.

Function
REQ-017 Per-edge priority SHALL be rst, then load, then en; with none of these active, q and qb hold.
REQ-018 load=1 SHALL set q to d on the edge regardless of en and mode, and SHALL drive wrap to 0.
REQ-019 In mode 00 with en=1, each bit i SHALL update independently: j/k 00 hold, 01 clear, 10 set, 11 toggle.
REQ-020 In mode 01 with en=1, q SHALL become q+1 modulo 2^WIDTH.
REQ-021 In mode 10 with en=1, q SHALL become q-1 modulo 2^WIDTH.
REQ-022 In mode 11 with en=1, q SHALL become {q[WIDTH-2:0], ser_in}.
REQ-023 wrap SHALL be 1 for exactly the cycle after an edge that changes q from all-ones to 0 in mode 01, or from 0 to all-ones in mode 10; otherwise 0.
REQ-024 A wrap caused by a JK toggle, a shift or a load SHALL NOT assert wrap.
REQ-025 A change of mode SHALL take effect on the same edge it is sampled; the operation on that edge uses the new mode.
REQ-026 en=0 with load=0 SHALL hold q and SHALL drive wrap to 0 on that edge.
REQ-027 Update latency SHALL be one clock: inputs sampled at edge N appear on q immediately after edge N.
REQ-028 No output SHALL be X after the first reset edge, for any input sequence without X.

Reset
REQ-029 rst=1 at an edge SHALL set q=RST_VAL, qb=~RST_VAL and wrap=0, overriding load, en, j, k and mode.
REQ-030 Reset asserted mid-count or mid-shift SHALL abandon the operation; after rst deasserts, operation resumes from RST_VAL with no residual wrap pulse.
REQ-031 Reset SHALL NOT be asynchronous; rst pulses between edges SHALL have no effect.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-032 rst=1, one edge -> q=0000, qb=1111, wrap=0; repeat with RST_VAL=4'hA -> q=1010, qb=0101.
REQ-033 mode 00, en=1, q=0000, j=1100, k=1010 -> q=1100 (bit3 toggle, bit2 set, bit1 clear, bit0 hold); apply again -> q=0100.
REQ-034 mode 01, en=1, load d=1110, then 3 edges -> q goes 1111 (tc=1), 0000 (wrap=1 for that one cycle), 0001 (wrap=0).
REQ-035 mode 10, en=1, q=0001, 2 edges -> q=0000 (tc=1), then 1111 with wrap=1; en=0 on the next edge -> q holds 1111, wrap=0.
REQ-036 mode 11, en=1, q=0000, ser_in sequence 1,0,1,1 -> q=1011, ser_out=1; load=1 with en=0 and d=0110 -> q=0110.
REQ-037 mode 01 counting at q=0111 with rst=1 and load=1 on the same edge -> q=0000, wrap=0; load alone wins over en when rst=0.
